// File: rtl/cpu6_bus_pkg.sv
// Shared types and constants for the CPU6 memory-bus arbitration logic.
package cpu6_bus_pkg;

    localparam int BUS_AW = 16;
    localparam int BUS_DW = 8;

    localparam logic [2:0] OWNER_CPU = 3'd0;

    typedef enum logic [1:0] {
        CPU_OWN = 2'd0,
        HOLD    = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arbState_t;

endpackage

// File: rtl/cpu6_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_picker #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] idx,
    output logic          any
);

    localparam int unsigned NU = N;

    always_comb begin
        int unsigned j;
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        j    = 0;
        for (int unsigned i = 0; i < NU; i++) begin
            j = 32'(ptr) + i;
            if (j >= NU) j = j - NU;
            if (!any && req[j]) begin
                any     = 1'b1;
                pick[j] = 1'b1;
                idx     = PW'(j);
            end
        end
    end

endmodule

// File: rtl/cpu6_bus_arbiter.sv
// Shares the CPU6 bus between the CPU (default owner) and NUM_DMA round-robin
// DMA requesters; the CPU is stalled via cpu_hold only at bus-cycle boundaries.
module cpu6_bus_arbiter
    import cpu6_bus_pkg::*;
#(
    parameter int NUM_DMA   = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [BUS_AW-1:0]         cpu_addr,
    input  logic [BUS_DW-1:0]         cpu_wdata,
    input  logic                      cpu_we,
    input  logic                      cpu_cycle_end,
    output logic                      cpu_hold,
    input  logic [NUM_DMA-1:0]        dma_req,
    output logic [NUM_DMA-1:0]        dma_gnt,
    input  logic [NUM_DMA*BUS_AW-1:0] dma_addr,
    input  logic [NUM_DMA*BUS_DW-1:0] dma_wdata,
    input  logic [NUM_DMA-1:0]        dma_we,
    output logic [BUS_AW-1:0]         bus_addr,
    output logic [BUS_DW-1:0]         bus_wdata,
    output logic                      bus_we,
    output logic [2:0]                bus_owner
);

    localparam int IDX_W = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DMA - 1);

    arbState_t          state;
    logic               credit;
    logic [IDX_W-1:0]   rrPtr;
    logic [CNT_W-1:0]   beatCnt;
    logic [CNT_W-1:0]   beatNext;
    logic [NUM_DMA-1:0] winOh;
    logic [IDX_W-1:0]   winIdx;
    logic [IDX_W-1:0]   ptrAfterWin;
    logic               winReq;

    logic [NUM_DMA-1:0] pickOh;
    logic [IDX_W-1:0]   pickIdx;
    logic               pickAny;

    rr_picker #(
        .N  (NUM_DMA),
        .PW (IDX_W)
    ) uPick (
        .req  (dma_req),
        .ptr  (rrPtr),
        .pick (pickOh),
        .idx  (pickIdx),
        .any  (pickAny)
    );

    assign winReq      = |(dma_req & winOh);
    assign ptrAfterWin = (winIdx == IDX_LAST) ? '0 : winIdx + 1'b1;
    assign beatNext    = (beatCnt == BURST_LAST) ? beatCnt : beatCnt + 1'b1;

    // Outputs are registered from the next-state decision, so they change
    // in the same cycle the state does.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= CPU_OWN;
            credit    <= 1'b1;
            rrPtr     <= '0;
            beatCnt   <= '0;
            winOh     <= '0;
            winIdx    <= '0;
            cpu_hold  <= 1'b0;
            dma_gnt   <= '0;
            bus_owner <= OWNER_CPU;
        end else begin
            case (state)
                CPU_OWN: begin
                    if (cpu_cycle_end) credit <= 1'b1;
                    if (credit && pickAny) begin
                        state    <= HOLD;
                        winOh    <= pickOh;
                        winIdx   <= pickIdx;
                        cpu_hold <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!winReq) begin
                        state    <= CPU_OWN;
                        cpu_hold <= 1'b0;
                    end else if (cpu_cycle_end) begin
                        state     <= GRANT;
                        beatCnt   <= '0;
                        credit    <= 1'b0;
                        dma_gnt   <= winOh;
                        bus_owner <= 3'(winIdx) + 3'd1;
                    end
                end
                GRANT: begin
                    beatCnt <= beatNext;
                    if (!winReq || beatNext == BURST_LAST) begin
                        state     <= RELEASE;
                        dma_gnt   <= '0;
                        bus_owner <= OWNER_CPU;
                        rrPtr     <= ptrAfterWin;
                    end
                end
                RELEASE: begin
                    state    <= CPU_OWN;
                    cpu_hold <= 1'b0;
                end
                default: begin
                    state    <= CPU_OWN;
                    cpu_hold <= 1'b0;
                    dma_gnt  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        logic weSel;
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        weSel     = cpu_we;
        for (int unsigned i = 0; i < NUM_DMA; i++) begin
            if (bus_owner == 3'(i + 1)) begin
                bus_addr  = dma_addr[i*BUS_AW +: BUS_AW];
                bus_wdata = dma_wdata[i*BUS_DW +: BUS_DW];
                weSel     = dma_we[i];
            end
        end
        bus_we = weSel && (state != RELEASE);
    end

endmodule

// File: tb/tb_cpu6_bus_arbiter.sv
// Scoreboard bench for cpu6_bus_arbiter: directed scenarios plus random traffic
// checked against a phase-level reference model.
module tb_cpu6_bus_arbiter;

    localparam int NUM  = 2;
    localparam int MAXB = 5;

    logic        clock;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_cycle_end;
    logic        cpu_hold;
    logic [1:0]  dma_req;
    logic [1:0]  dma_gnt;
    logic [31:0] dma_addr;
    logic [15:0] dma_wdata;
    logic [1:0]  dma_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic [2:0]  bus_owner;

    cpu6_bus_arbiter #(
        .NUM_DMA   (NUM),
        .MAX_BURST (MAXB)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_we        (cpu_we),
        .cpu_cycle_end (cpu_cycle_end),
        .cpu_hold      (cpu_hold),
        .dma_req       (dma_req),
        .dma_gnt       (dma_gnt),
        .dma_addr      (dma_addr),
        .dma_wdata     (dma_wdata),
        .dma_we        (dma_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_we        (bus_we),
        .bus_owner     (bus_owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        hold;
        logic [1:0]  gnt;
        logic [2:0]  owner;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        we;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;
    logic rstNext;

    // Reference model: who holds the bus and why, tracked per cycle.
    // mPhase: 0 = CPU owns, 1 = CPU being stopped, 2 = DMA tenure, 3 = hand-back.
    int mPhase, mPtr, mWin, mBeats;
    bit mCredit;

    int  runLen  = 0;
    int  lastLen = 0;
    bit  gntSeen = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    task automatic modelStep(input logic rst, input logic [1:0] r, input logic ce);
        bit found;
        if (!rst) begin
            mPhase = 0; mCredit = 1; mPtr = 0; mBeats = 0; mWin = 0;
            return;
        end
        case (mPhase)
            0: begin
                if (mCredit && r != 2'b00) begin
                    found = 0;
                    for (int n = 0; n < NUM; n++) begin
                        if (!found && r[(mPtr + n) % NUM]) begin
                            mWin  = (mPtr + n) % NUM;
                            found = 1;
                        end
                    end
                    mPhase = 1;
                end
                if (ce) mCredit = 1;
            end
            1: begin
                if (!r[mWin]) mPhase = 0;
                else if (ce) begin
                    mPhase = 2; mBeats = 0; mCredit = 0;
                end
            end
            2: begin
                mBeats = mBeats + 1;
                if (!r[mWin] || mBeats >= MAXB) begin
                    mPhase = 3;
                    mPtr   = (mWin + 1) % NUM;
                end
            end
            default: mPhase = 0;
        endcase
    endtask

    // Drive one cycle of inputs at the falling edge and queue the response
    // expected after the following rising edge.
    task automatic cyc(input logic [1:0] r, input logic ce);
        exp_t e;
        int   own;
        @(negedge clock);
        reset         = rstNext;
        dma_req       = r;
        cpu_cycle_end = ce;
        cpu_addr      = 16'($urandom);
        cpu_wdata     = 8'($urandom);
        cpu_we        = 1'($urandom);
        dma_addr      = $urandom;
        dma_wdata     = 16'($urandom);
        dma_we        = 2'($urandom);
        modelStep(reset, r, ce);
        own     = (mPhase == 2) ? mWin + 1 : 0;
        e.hold  = (mPhase != 0);
        e.gnt   = (mPhase == 2) ? 2'(1 << mWin) : 2'b00;
        e.owner = 3'(own);
        if (own == 0) begin
            e.addr = cpu_addr; e.wdata = cpu_wdata; e.we = cpu_we;
        end else begin
            e.addr  = dma_addr[(own-1)*16 +: 16];
            e.wdata = dma_wdata[(own-1)*8 +: 8];
            e.we    = dma_we[own-1];
        end
        if (mPhase == 3) e.we = 1'b0;
        expQ.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("cpu_hold",  32'(cpu_hold),  32'(e.hold));
                chk("dma_gnt",   32'(dma_gnt),   32'(e.gnt));
                chk("bus_owner", 32'(bus_owner), 32'(e.owner));
                chk("bus_addr",  32'(bus_addr),  32'(e.addr));
                chk("bus_wdata", 32'(bus_wdata), 32'(e.wdata));
                chk("bus_we",    32'(bus_we),    32'(e.we));
            end
            if (dma_gnt != 2'b00) begin
                runLen++;
                gntSeen = 1;
            end else if (runLen > 0) begin
                chk("grant_len_le_max", 32'(runLen <= MAXB), 32'd1);
                lastLen = runLen;
                runLen  = 0;
            end
        end
    end

    initial begin
        logic [1:0] rq;
        reset = 1'b0; rstNext = 1'b0;
        dma_req = '0; cpu_cycle_end = 1'b0;
        cpu_addr = 16'h1234; cpu_wdata = 8'h5A; cpu_we = 1'b1;
        dma_addr = '0; dma_wdata = '0; dma_we = '0;
        #1;
        chk("reset_bus_addr",  32'(bus_addr),  32'h1234);
        chk("reset_bus_we",    32'(bus_we),    32'd1);
        chk("reset_cpu_hold",  32'(cpu_hold),  32'd0);
        chk("reset_dma_gnt",   32'(dma_gnt),   32'd0);
        chk("reset_bus_owner", 32'(bus_owner), 32'd0);
        cyc(2'b00, 1'b0);
        cyc(2'b00, 1'b0);
        rstNext = 1'b1;

        // Single DMA: request at cycle 0, boundary at cycle 1, drop at cycle 6
        // (coincides with the burst limit of 5).
        cyc(2'b01, 1'b0);
        cyc(2'b01, 1'b1);
        for (int i = 0; i < 4; i++) cyc(2'b01, 1'($urandom));
        cyc(2'b00, 1'b0);
        cyc(2'b00, 1'b0);
        cyc(2'b00, 1'b0);
        chk("single_grant_len", 32'(lastLen), 32'd5);

        // Burst limit with no CPU boundary afterwards: no re-grant.
        for (int i = 0; i < 3; i++) cyc(2'b00, 1'b1);
        cyc(2'b01, 1'b0);
        cyc(2'b01, 1'b1);
        for (int i = 0; i < 12; i++) cyc(2'b01, 1'b0);
        chk("burst_grant_len", 32'(lastLen), 32'(MAXB));
        for (int i = 0; i < 8; i++) cyc(2'b01, 1'b1);

        // Round-robin with both requesters saturating.
        for (int i = 0; i < 40; i++) cyc(2'b11, 1'($urandom));

        // Withdrawal while the CPU is being stopped.
        for (int i = 0; i < 3; i++) cyc(2'b00, 1'b1);
        gntSeen = 0;
        cyc(2'b10, 1'b0);
        cyc(2'b10, 1'b0);
        cyc(2'b00, 1'b0);
        cyc(2'b00, 1'b0);
        chk("withdraw_no_grant", 32'(gntSeen), 32'd0);

        // Random traffic.
        rq = 2'b00;
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < NUM; k++) begin
                if (!rq[k]) rq[k] = ($urandom_range(3) == 0);
                else        rq[k] = ($urandom_range(9) != 0);
            end
            cyc(rq, 1'($urandom_range(2) == 0));
        end

        // Asynchronous reset in the middle of a tenure.
        for (int i = 0; i < 20 && mPhase != 2; i++) cyc(2'b11, 1'b1);
        cyc(2'b11, 1'b0);
        @(posedge clock);
        #3;
        chk("pre_reset_gnt_active", 32'(dma_gnt != 2'b00), 32'd1);
        reset = 1'b0; rstNext = 1'b0;
        #1;
        chk("async_rst_dma_gnt",   32'(dma_gnt),   32'd0);
        chk("async_rst_cpu_hold",  32'(cpu_hold),  32'd0);
        chk("async_rst_bus_owner", 32'(bus_owner), 32'd0);
        cyc(2'b11, 1'b1);
        rstNext = 1'b1;
        cyc(2'b11, 1'b0);
        cyc(2'b11, 1'b1);
        cyc(2'b11, 1'b0);
        chk("post_reset_rr_dma0", 32'(dma_gnt), 32'h1);
        for (int i = 0; i < 10; i++) cyc(2'b00, 1'b1);

        @(posedge clock);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
